// File: rtl/cpu_control_fsm.sv
// Multi-cycle RV32 control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, raises the datapath strobes for each step,
// counts retired instructions and parks in a sticky FAULT state on an
// illegal opcode or a memory that never answers.
module cpu_control_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_a_pc,
  output logic        alu_b_imm,
  output logic        alu_force_add,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Last wait cycle tolerated before giving up on a memory
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q, instret_d;
  logic [6:0]  opc_q, opc_d;
  logic        retire;
  logic        waiting;
  logic        unused_instr_bits;

  // Only the opcode field steers the sequencer; the rest belongs to the datapath
  assign unused_instr_bits = ^instruction[31:7];

  // State register, wait counter, opcode latched in DECODE and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      instret_q <= 32'd0;
      opc_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      opc_q     <= opc_d;
    end
  end

  // Next-state and strobe decode; reset masks every strobe in the same cycle
  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    retire        = 1'b0;
    waiting       = 1'b0;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    alu_a_pc      = 1'b0;
    alu_b_imm     = 1'b0;
    alu_force_add = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        opc_d = instruction[6:0];
        case (instruction[6:0])
          OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP,
          OPC_LOAD, OPC_STORE, OPC_JAL, OPC_BRANCH: state_d = S_EXEC;
          default:                                  state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (opc_q)
          OPC_LUI, OPC_OP: state_d = S_WB;
          OPC_OPIMM: begin
            alu_b_imm = 1'b1;
            state_d   = S_WB;
          end
          OPC_AUIPC, OPC_JAL: begin
            alu_a_pc      = 1'b1;
            alu_b_imm     = 1'b1;
            alu_force_add = 1'b1;
            state_d       = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_b_imm     = 1'b1;
            alu_force_add = 1'b1;
            state_d       = S_MEM;
          end
          OPC_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc_q == OPC_STORE);
        if (dmem_ready) begin
          if (opc_q == OPC_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_src  = (opc_q == OPC_JAL);
        retire  = 1'b1;
        state_d = S_FETCH;
        case (opc_q)
          OPC_LUI:  wb_sel = 2'd2;
          OPC_LOAD: wb_sel = 2'd1;
          OPC_JAL:  wb_sel = 2'd3;
          default:  wb_sel = 2'd0;
        endcase
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    if (rst) begin
      retire        = 1'b0;
      imem_req      = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 1'b0;
      alu_a_pc      = 1'b0;
      alu_b_imm     = 1'b0;
      alu_force_add = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      rf_we         = 1'b0;
      wb_sel        = 2'd0;
    end

    wait_d    = (state_d != state_q) ? 8'd0 : (waiting ? wait_q + 8'd1 : wait_q);
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  assign state   = rst ? 3'd0 : state_q;
  assign fault   = ~rst & (state_q == S_FAULT);
  assign instret = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized scoreboard bench for cpu_control_fsm: the driver pushes the
// expected outcome of each instruction, a monitor pops it when the DUT
// retires (pc_we) or enters FAULT and compares what it observed.
module tb_cpu_control_fsm;

  localparam int TO = 16;

  localparam int C_LUI     = 0;
  localparam int C_AUIPC   = 1;
  localparam int C_OPIMM   = 2;
  localparam int C_OP      = 3;
  localparam int C_LOAD    = 4;
  localparam int C_STORE   = 5;
  localparam int C_JAL     = 6;
  localparam int C_BRANCH  = 7;
  localparam int C_ILLEGAL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_we, pc_we, pc_src, alu_a_pc, alu_b_imm, alu_force_add;
  logic        dmem_req, dmem_we, rf_we, fault;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  typedef struct {
    bit          is_fault;
    bit [2:0]    exp_state;
    bit          pc_src;
    bit          rf_we;
    bit [1:0]    wb_sel;
    logic [31:0] instret;
    int          lat;
    int          fetch_cyc;
    int          ir_cyc;
    int          mem_cyc;
    int          we_cyc;
    bit [2:0]    alu;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_instret;

  int          mon_cyc, mon_fetch, mon_ir, mon_mem, mon_we;
  logic [2:0]  mon_alu;
  logic        mon_prev_fault;
  exp_t        mon_e;

  cpu_control_fsm #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .alu_force_add(alu_force_add),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .fault(fault), .instret(instret)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  function automatic logic [6:0] opcodeOf(input int cls);
    case (cls)
      C_LUI:    return 7'b0110111;
      C_AUIPC:  return 7'b0010111;
      C_OPIMM:  return 7'b0010011;
      C_OP:     return 7'b0110011;
      C_LOAD:   return 7'b0000011;
      C_STORE:  return 7'b0100011;
      C_JAL:    return 7'b1101111;
      C_BRANCH: return 7'b1100011;
      default:  return 7'b1111111;
    endcase
  endfunction

  function automatic bit isLegal(input logic [6:0] opc);
    for (int c = 0; c < 8; c++)
      if (opcodeOf(c) == opc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] strobes();
    return {20'd0, imem_req, ir_we, pc_we, pc_src, alu_a_pc, alu_b_imm,
            alu_force_add, dmem_req, dmem_we, rf_we, wb_sel};
  endfunction

  // Reference outcome of one instruction: f = fetch wait cycles, n = memory wait cycles
  function automatic exp_t model(input int cls, input int f, input int n, input bit bt,
                                 input logic [31:0] cnt);
    exp_t e;
    e = '{default: 0};
    e.instret = cnt;
    if (f >= TO) begin
      e.is_fault  = 1'b1;
      e.exp_state = 3'd5;
      e.lat       = TO;
      e.fetch_cyc = TO;
      return e;
    end
    e.fetch_cyc = f + 1;
    e.ir_cyc    = 1;
    if (cls == C_ILLEGAL) begin
      e.is_fault  = 1'b1;
      e.exp_state = 3'd5;
      e.lat       = f + 2;
    end else if (cls == C_BRANCH) begin
      e.exp_state = 3'd2;
      e.lat       = f + 2;
      e.pc_src    = bt;
    end else if (cls == C_LOAD || cls == C_STORE) begin
      e.alu = 3'b011;
      if (n >= TO) begin
        e.is_fault  = 1'b1;
        e.exp_state = 3'd5;
        e.lat       = f + 3 + TO;
        e.mem_cyc   = TO;
        e.we_cyc    = (cls == C_STORE) ? TO : 0;
      end else if (cls == C_STORE) begin
        e.exp_state = 3'd3;
        e.lat       = f + 3 + n;
        e.mem_cyc   = n + 1;
        e.we_cyc    = n + 1;
      end else begin
        e.exp_state = 3'd4;
        e.lat       = f + 4 + n;
        e.mem_cyc   = n + 1;
        e.rf_we     = 1'b1;
        e.wb_sel    = 2'd1;
      end
    end else begin
      e.exp_state = 3'd4;
      e.lat       = f + 3;
      e.rf_we     = 1'b1;
      e.wb_sel    = (cls == C_LUI) ? 2'd2 : (cls == C_JAL) ? 2'd3 : 2'd0;
      e.pc_src    = (cls == C_JAL);
      e.alu       = (cls == C_OPIMM) ? 3'b010 :
                    (cls == C_AUIPC || cls == C_JAL) ? 3'b111 : 3'b000;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for one cycle with every input active, checking the masked outputs
  task automatic doReset();
    rst = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_strobes", strobes(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    model_instret = 32'd0;
    #1;
    checkOutput("post_rst_state", 32'(state), 32'd0);
    checkOutput("post_rst_imem_req", 32'(imem_req), 32'd1);
  endtask

  // Drive one instruction; starts and ends at the beginning of a FETCH cycle
  task automatic applyStimulus(input int cls, input int f, input int n, input bit bt,
                               input logic [31:0] word, input bit wrap);
    exp_t e;
    if (wrap) model_instret = 32'hFFFF_FFFF;
    e = model(cls, f, n, bt, model_instret);
    sb.push_back(e);
    if (!e.is_fault) model_instret = model_instret + 32'd1;
    instruction = word;
    branch_taken = bt;
    dmem_ready = 1'b0;
    imem_ready = 1'b0;
    if (f >= TO) begin
      repeat (TO + 2) step();
      doReset();
      return;
    end
    for (int i = 0; i < f; i++) begin
      if (wrap && i == 0) force dut.instret_q = 32'hFFFF_FFFF;
      step();
      if (wrap && i == 0) release dut.instret_q;
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    if (cls == C_ILLEGAL) begin
      repeat (2) step();
      doReset();
      return;
    end
    step();
    if (cls == C_BRANCH) return;
    if (cls == C_LOAD || cls == C_STORE) begin
      if (n >= TO) begin
        repeat (TO + 2) step();
        doReset();
        return;
      end
      repeat (n) step();
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
      if (cls == C_STORE) return;
    end
    step();
  endtask

  // Monitor: tally activity per instruction, compare on each retire or fault entry
  initial begin
    mon_cyc = 0; mon_fetch = 0; mon_ir = 0; mon_mem = 0; mon_we = 0;
    mon_alu = 3'd0; mon_prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_cyc = 0; mon_fetch = 0; mon_ir = 0; mon_mem = 0; mon_we = 0;
        mon_alu = 3'd0; mon_prev_fault = 1'b0;
      end else begin
        if (imem_req) mon_fetch++;
        if (ir_we) mon_ir++;
        if (dmem_req) mon_mem++;
        if (dmem_req && dmem_we) mon_we++;
        if (state == 3'd2) mon_alu = {alu_a_pc, alu_b_imm, alu_force_add};
        if (rf_we) checkOutput("rf_we_with_pc_we", 32'(pc_we), 32'd1);
        if (dmem_we) checkOutput("dmem_we_with_req", 32'(dmem_req), 32'd1);
        if (fault) checkOutput("fault_strobes_idle", strobes(), 32'd0);
        if (pc_we || (fault && !mon_prev_fault)) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event pc_we=%0b fault=%0b expected no event", pc_we, fault);
          end else begin
            mon_e = sb.pop_front();
            checkOutput("evt_state", 32'(state), 32'(mon_e.exp_state));
            checkOutput("evt_fault", 32'(fault), 32'(mon_e.is_fault));
            checkOutput("evt_pc_src", 32'(pc_src), 32'(mon_e.pc_src));
            checkOutput("evt_rf_we", 32'(rf_we), 32'(mon_e.rf_we));
            checkOutput("evt_wb_sel", 32'(wb_sel), 32'(mon_e.wb_sel));
            checkOutput("evt_instret", instret, mon_e.instret);
            checkOutput("evt_latency", 32'(mon_cyc), 32'(mon_e.lat));
            checkOutput("evt_fetch_cycles", 32'(mon_fetch), 32'(mon_e.fetch_cyc));
            checkOutput("evt_ir_we_count", 32'(mon_ir), 32'(mon_e.ir_cyc));
            checkOutput("evt_mem_cycles", 32'(mon_mem), 32'(mon_e.mem_cyc));
            checkOutput("evt_store_cycles", 32'(mon_we), 32'(mon_e.we_cyc));
            checkOutput("evt_alu_sel", 32'(mon_alu), 32'(mon_e.alu));
          end
          mon_cyc = 0; mon_fetch = 0; mon_ir = 0; mon_mem = 0; mon_we = 0;
          mon_alu = 3'd0;
        end else begin
          mon_cyc++;
        end
        mon_prev_fault = fault;
      end
    end
  end

  // Hard stop in case the run never reaches its summary
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios first, then randomized instruction mix
  initial begin
    rst = 1'b1;
    instruction = 32'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    model_instret = 32'd0;
    step();
    doReset();

    applyStimulus(C_LUI, 0, 0, 1'b0, 32'h1234_50B7, 1'b0);
    checkOutput("lui_instret", instret, 32'd1);
    applyStimulus(C_BRANCH, 0, 0, 1'b1, 32'h0020_8063, 1'b0);
    applyStimulus(C_BRANCH, 1, 0, 1'b0, 32'h0020_8063, 1'b0);
    applyStimulus(C_STORE, 0, 3, 1'b0, 32'h0020_A023, 1'b0);
    applyStimulus(C_LOAD, 0, 2, 1'b0, 32'h0000_A183, 1'b0);
    applyStimulus(C_JAL, 0, 0, 1'b0, 32'h0080_00EF, 1'b0);
    applyStimulus(C_AUIPC, 2, 0, 1'b0, 32'h0000_1097, 1'b0);
    applyStimulus(C_OP, 0, 0, 1'b0, 32'h0020_81B3, 1'b0);
    checkOutput("directed_instret", instret, model_instret);
    applyStimulus(C_OPIMM, TO, 0, 1'b0, 32'h0010_8093, 1'b0);
    applyStimulus(C_OPIMM, TO - 1, 0, 1'b0, 32'h0010_8093, 1'b0);
    applyStimulus(C_ILLEGAL, 0, 0, 1'b0, 32'h0000_007F, 1'b0);
    applyStimulus(C_LOAD, 0, TO, 1'b0, 32'h0000_A183, 1'b0);
    applyStimulus(C_STORE, 0, TO - 1, 1'b0, 32'h0020_A023, 1'b0);

    // Reset in the middle of a store's memory phase
    instruction = 32'h0020_A023;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    repeat (3) step();
    doReset();

    applyStimulus(C_OPIMM, 1, 0, 1'b0, 32'h0010_8093, 1'b1);
    checkOutput("wrap_instret", instret, 32'd0);
    checkOutput("wrap_fault", 32'(fault), 32'd0);

    for (int k = 0; k < 200; k++) begin
      int          cls, f, n, r;
      bit          bt;
      logic [6:0]  opc;
      logic [31:0] word;
      r = $urandom_range(0, 19);
      cls = (r == 19) ? C_ILLEGAL : r % 8;
      r = $urandom_range(0, 19);
      f = (r == 19) ? TO : (r == 18) ? TO - 1 : $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      n = (r == 19) ? TO : (r == 18) ? TO - 1 : $urandom_range(0, 3);
      bt = 1'($urandom_range(0, 1));
      opc = opcodeOf(cls);
      if (cls == C_ILLEGAL) begin
        opc = 7'($urandom_range(0, 127));
        while (isLegal(opc)) opc = 7'($urandom_range(0, 127));
      end
      word = ($urandom() & 32'hFFFF_FF80) | {25'd0, opc};
      applyStimulus(cls, f, n, bt, word, 1'b0);
    end

    repeat (3) step();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    checkOutput("final_instret", instret, model_instret);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
